vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing generator driving the 14-bit VGA output bus of the top level.
//  - Runs in the vga_clk domain (25 MHz pixel clock, 640x480@60 by default).
//  - Issues pixel coordinates upstream to the framebuffer, then takes back the fetched
//    12-bit colour and emits {hsync, vsync, rgb} aligned to that colour.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync pulse width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines)
//  SYNC_POL   0    asserted sync level (0 = active-low)
//  FETCH_LAT  1    cycles from pix_x/pix_y to valid rgb_i (range 1..4)
// PORTS
//  vga_clk         in   1   pixel clock
//  reset_n         in   1   asynchronous active-low reset
//  pix_x           out  10  column of the pixel being requested
//  pix_y           out  10  row of the pixel being requested
//  pix_active      out  1   pix_x/pix_y lie inside the visible area
//  frame_start     out  1   1-cycle pulse with pix (0,0)
//  rgb_i           in   12  fetched colour {R[3:0],G[3:0],B[3:0]}; valid FETCH_LAT cycles after its pix_x/pix_y
//  test_pattern_i  in   1   select colour bars (port present only with VGA_TEST_PATTERN_EN)
//  vgaData         out  14  {hsync[13], vsync[12], rgb[11:0]}
// BEHAVIOUR
//  - Clock and reset: one clock, vga_clk. reset_n is asynchronous and active-low.
//  - Counters: h_cnt wraps 0..H_TOTAL-1 (800). v_cnt advances when h_cnt wraps and itself
//    wraps 0..V_TOTAL-1 (525). Both reset to 0.
//  - Stage 0 (registered from the counters):
//    - pix_x = h_cnt, pix_y = v_cnt.
//    - pix_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//    - frame_start = (h_cnt == 0) && (v_cnt == 0).
//  - Sync decode (stage 0): hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//    vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//    Asserted level = SYNC_POL.
//  - Delay line: hsync, vsync and active pass through a FETCH_LAT-deep register delay.
//  - Output register: on the edge where rgb_i is valid, vgaData is loaded with
//    {hsync_d, vsync_d, active_d ? rgb_i : 12'h000}.
//  - Latency: vgaData for pixel (x,y) appears FETCH_LAT+1 cycles after pix_x==x, pix_y==y.
//    Sync and colour always stay mutually aligned.
//  - Reset values: pix_x=0, pix_y=0, pix_active=0, frame_start=0, delay line holds deasserted
//    syncs with active=0, vgaData={~SYNC_POL,~SYNC_POL,12'h000} (14'h3000 at default).
//  - Reset mid-frame: every output takes its reset value immediately (asynchronous).
//  - Reset release: at the first vga_clk edge after release, pix=(0,0), pix_active=1,
//    frame_start=1. Blank data then drains from the delay line for FETCH_LAT+1 cycles.
//  - Wrap boundaries:
//    - h_cnt=799 -> 0 with v_cnt+1 in the same cycle.
//    - (799,524) -> (0,0) raises frame_start on the next stage-0 register update.
//  - No back-pressure: the upstream source must return rgb_i with exactly FETCH_LAT cycles
//    of latency, every cycle. rgb_i is ignored whenever active_d = 0.
//  - Width rules: H_TOTAL and V_TOTAL must be <= 1024 (10-bit counters). The pix_x/pix_y
//    value presented on a wrap cycle is never out of range.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined:
//  - Adds the test_pattern_i port.
//  - When test_pattern_i=1, the active-pixel colour comes from the delayed x, not rgb_i:
//    8 vertical bars of H_ACTIVE/8 px each: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
//  - test_pattern_i is sampled at stage 0 and delayed with the syncs.
//  - Blanking rules are unchanged.
//  VGA_TEST_PATTERN_EN undefined:
//  - No test_pattern_i port and no bar logic.
//  - Colour always comes from rgb_i.
// TESTING
//  1. Hold reset_n=0 -> vgaData=14'h3000, pix_active=0, frame_start=0.
//     Release -> first edge gives pix=(0,0), frame_start=1.
//  2. Free run -> hsync (vgaData[13]) low for exactly 96 cycles, once per 800 cycles.
//     Falling edge FETCH_LAT+1 cycles after pix_x==656.
//  3. Free run -> vsync low for exactly 1600 cycles, starting where pix_y==490 with
//     pix_x==0 (+FETCH_LAT+1). frame_start period is exactly 420000 cycles.
//  4. rgb_i=12'hFFF constant -> vgaData[11:0]=FFF on exactly 640 consecutive cycles per
//     visible line and 000 elsewhere. No non-zero rgb on lines 480..524.
//  5. Model returns rgb_i=pix_x[11:0] after FETCH_LAT cycles (run FETCH_LAT=1 and 3) ->
//     each visible cycle, vgaData[11:0] equals the x issued FETCH_LAT+1 cycles earlier.
//  6. With VGA_TEST_PATTERN_EN, test_pattern_i=1:
//     - x 0..79 gives FFF, x 80..159 gives FF0, x 560..639 gives 000.
//     - Dropping reset_n mid-line forces vgaData=14'h3000 before the next edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- raster timing generator for the 14-bit VGA output bus.
//
// Pipeline: free-running h/v counters -> stage-0 registers (pixel request and
// sync decode) -> FETCH_LAT-deep delay line -> output register. The output
// register captures rgb_i on the same edge that the delayed syncs arrive, so
// sync and colour always stay aligned. vgaData for a pixel appears
// FETCH_LAT+1 cycles after that pixel is presented on pix_x/pix_y.
//
// Ports:
//   vga_clk         in   1   pixel clock
//   reset_n         in   1   asynchronous active-low reset
//   pix_x           out  10  column of the pixel being requested
//   pix_y           out  10  row of the pixel being requested
//   pix_active      out  1   pix_x/pix_y lie inside the visible area
//   frame_start     out  1   1-cycle pulse together with pixel (0,0)
//   rgb_i           in   12  fetched colour {R,G,B}, valid FETCH_LAT cycles after its pixel
//   test_pattern_i  in   1   select colour bars (only with VGA_TEST_PATTERN_EN)
//   vgaData         out  14  {hsync, vsync, rgb[11:0]}
//
// Build option: define VGA_TEST_PATTERN_EN to add test_pattern_i and an
// 8-bar colour pattern generated from the delayed x position.

module vga_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   FETCH_LAT = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_active,
  output logic        frame_start,
  input  logic [11:0] rgb_i,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern_i,
`endif
  output logic [13:0] vgaData
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit limits so that a sync window ending exactly at 1024 still fits.
  localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
`endif

  // Everything that travels with a pixel through the delay line.
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
`ifdef VGA_TEST_PATTERN_EN
    logic       tp;
    logic [2:0] bar;
`endif
  } line_t;

  function automatic line_t line_idle();
    line_t w;
    w       = '0;
    w.hsync = ~SYNC_POL;
    w.vsync = ~SYNC_POL;
    return w;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  // Bars in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000: each channel is a
  // single inverted bit of the bar index.
  function automatic logic [11:0] bar_colour(input logic [2:0] b);
    return {{4{~b[1]}}, {4{~b[2]}}, {4{~b[0]}}};
  endfunction
`endif

  // ---------------------------------------------------------------- counters
  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;

  always_comb begin
    h_cnt_next = h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = 10'd0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_reg <= 10'd0;
      v_cnt_reg <= 10'd0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // ---------------------------------------------------------------- stage 0
  line_t s0_next, s0_reg;
  logic  h_vis, v_vis;

  assign h_vis = {1'b0, h_cnt_reg} < H_ACT_L;
  assign v_vis = {1'b0, v_cnt_reg} < V_ACT_L;

  always_comb begin
    s0_next        = '0;
    s0_next.hsync  = ({1'b0, h_cnt_reg} >= HS_START && {1'b0, h_cnt_reg} < HS_END)
                     ? SYNC_POL : ~SYNC_POL;
    s0_next.vsync  = ({1'b0, v_cnt_reg} >= VS_START && {1'b0, v_cnt_reg} < VS_END)
                     ? SYNC_POL : ~SYNC_POL;
    s0_next.active = h_vis && v_vis;
`ifdef VGA_TEST_PATTERN_EN
    s0_next.tp     = test_pattern_i;
    // Out-of-range bar indices only occur in blanking, where colour is forced to 0.
    s0_next.bar    = 3'(h_cnt_reg / BAR_W);
`endif
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_active  <= 1'b0;
      frame_start <= 1'b0;
      s0_reg      <= line_idle();
    end else begin
      pix_x       <= h_cnt_reg;
      pix_y       <= v_cnt_reg;
      pix_active  <= h_vis && v_vis;
      frame_start <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
      s0_reg      <= s0_next;
    end
  end

  // ------------------------------------------------------------- delay line
  // Matches the upstream fetch latency so the syncs meet their colour.
  for (genvar gi = 0; gi < FETCH_LAT; gi++) begin : g_dly
    line_t q_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) q_reg <= line_idle();
        else          q_reg <= s0_reg;
      end
    end else begin : g_tail
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) q_reg <= line_idle();
        else          q_reg <= g_dly[gi-1].q_reg;
      end
    end
  end

  line_t dly_out;
  assign dly_out = g_dly[FETCH_LAT-1].q_reg;

  // ------------------------------------------------------- output register
  logic [11:0] colour_next;

  always_comb begin
    colour_next = 12'h000;
    if (dly_out.active) begin
`ifdef VGA_TEST_PATTERN_EN
      if (dly_out.tp) colour_next = bar_colour(dly_out.bar);
      else            colour_next = rgb_i;
`else
      colour_next = rgb_i;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) vgaData <= {~SYNC_POL, ~SYNC_POL, 12'h000};
    else          vgaData <= {dly_out.hsync, dly_out.vsync, colour_next};
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances (default 640x480 timing with
// FETCH_LAT=1, and a tiny 16x8 raster with FETCH_LAT=3 and active-high syncs)
// checked every cycle against an arithmetic raster model, plus a table of
// hand-computed points and hand-written reset sequences.

module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
    bit pol;
  } cfg_t;

  typedef struct {
    int          t;      // edges since reset release
    logic [9:0]  x, y;
    logic        act, fs;
    logic [13:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [11:0] rgb_a, rgb_b;
  logic        tp_a, tp_b;
  logic [9:0]  px_a, py_a, px_b, py_b;
  logic        act_a, fs_a, act_b, fs_b;
  logic [13:0] data_a, data_b;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .vga_clk(clk), .reset_n(rst_a), .pix_x(px_a), .pix_y(py_a),
    .pix_active(act_a), .frame_start(fs_a), .rgb_i(rgb_a),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern_i(tp_a),
`endif
    .vgaData(data_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .FETCH_LAT(3)
  ) dut_b (
    .vga_clk(clk), .reset_n(rst_b), .pix_x(px_b), .pix_y(py_b),
    .pix_active(act_b), .frame_start(fs_b), .rgb_i(rgb_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern_i(tp_b),
`endif
    .vgaData(data_b)
  );

  int errors = 0;
  int checks = 0;
  int shown  = 0;

  cfg_t cfg_a, cfg_b;
  int   ta = 0, tb_n = 0;
  logic [11:0] ca_h [4096];
  logic [11:0] cb_h [4096];
  bit          tpa_h [4096];
  bit          tpb_h [4096];

  int  hs_run_a = 0, vs_run_b = 0, last_fs_b = 0;
  bit  b_rst_done = 1'b0;
  int  b_hold = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      if (shown < 40)
        $display("FAIL %s @%0t: got %0h want %0h", name, $time, got, want);
      shown++;
    end
  endtask

  function automatic logic [11:0] bar_model(input int b);
    case (b)
      0: return 12'hFFF;  1: return 12'hFF0;  2: return 12'h0FF;  3: return 12'h0F0;
      4: return 12'hF0F;  5: return 12'hF00;  6: return 12'h00F;  default: return 12'h000;
    endcase
  endfunction

  // Pixel presented after edge t (t=0: still in reset / no edge yet).
  function automatic logic [21:0] m_pix(input cfg_t c, input int t);
    int p, ht, vt, x, y;
    logic a, f;
    if (t == 0) return 22'd0;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    p  = t - 1;
    x  = p % ht;
    y  = (p / ht) % vt;
    a  = (x < c.ha) && (y < c.va);
    f  = (x == 0) && (y == 0);
    return {10'(x), 10'(y), a, f};
  endfunction

  // vgaData after edge t: the pixel issued lat+1 edges earlier, or reset data.
  function automatic logic [13:0] m_data(input cfg_t c, input int t,
                                         input logic [11:0] col, input bit tp);
    int p, ht, vt, x, y;
    logic hs, vs;
    logic [11:0] rgb;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    p  = t - c.lat - 2;
    if (p < 0) return {~c.pol, ~c.pol, 12'h000};
    x  = p % ht;
    y  = (p / ht) % vt;
    hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.pol : ~c.pol;
    vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.pol : ~c.pol;
    rgb = 12'h000;
    if (x < c.ha && y < c.va) rgb = tp ? bar_model(x / (c.ha / 8)) : col;
    return {hs, vs, rgb};
  endfunction

  task automatic step();
    int idx;
    logic [11:0] col;
    bit tpv;
    @(posedge clk);
    #1;
    if (rst_a) ta++;
    if (rst_b) tb_n++;
    tpa_h[ta]   = tp_a;
    tpb_h[tb_n] = tp_b;

    chk("a_pix", 64'({px_a, py_a, act_a, fs_a}), 64'(m_pix(cfg_a, ta)));
    idx = ta - cfg_a.lat - 1;
    col = (idx >= 1) ? ca_h[idx] : 12'h000;
    tpv = (idx >= 1) ? tpa_h[idx] : 1'b0;
    chk("a_data", 64'(data_a), 64'(m_data(cfg_a, ta, col, tpv)));

    chk("b_pix", 64'({px_b, py_b, act_b, fs_b}), 64'(m_pix(cfg_b, tb_n)));
    idx = tb_n - cfg_b.lat - 1;
    col = (idx >= 1) ? cb_h[idx] : 12'h000;
    tpv = (idx >= 1) ? tpb_h[idx] : 1'b0;
    chk("b_data", 64'(data_b), 64'(m_data(cfg_b, tb_n, col, tpv)));

    // hsync pulse width on the default-timing instance
    if (ta > 3) begin
      if (data_a[13] == 1'b0) hs_run_a++;
      else if (hs_run_a > 0) begin
        chk("a_hsync_width", 64'(hs_run_a), 64'd96);
        hs_run_a = 0;
      end
    end
    // vsync width (2 lines of 24) and frame period (24*13) on the small raster
    if (tb_n > 0) begin
      if (data_b[12] == 1'b1) vs_run_b++;
      else if (vs_run_b > 0) begin
        chk("b_vsync_width", 64'(vs_run_b), 64'd48);
        vs_run_b = 0;
      end
      if (fs_b) begin
        if (last_fs_b > 0) chk("b_frame_period", 64'(tb_n - last_fs_b), 64'd312);
        last_fs_b = tb_n;
      end
    end

    // Upstream fetch models: a returns pix_x, b returns random colours.
    ca_h[ta]   = {2'b00, px_a};
    rgb_a      = (ta - cfg_a.lat >= 1) ? ca_h[ta - cfg_a.lat] : 12'($urandom);
    cb_h[tb_n] = 12'($urandom);
    rgb_b      = (tb_n - cfg_b.lat >= 1) ? cb_h[tb_n - cfg_b.lat] : 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
    tp_b = 1'($urandom);
`endif

    // Mid-frame asynchronous reset of instance b, then release two edges later.
    if (!b_rst_done && tb_n == 150) begin
      #2;
      rst_b = 1'b0;
      #1;
      chk("b_async_rst_data", 64'(data_b), 64'h0000);
      chk("b_async_rst_pix", 64'({px_b, py_b, act_b, fs_b}), 64'd0);
      tb_n = 0; vs_run_b = 0; last_fs_b = 0;
      b_rst_done = 1'b1;
    end else if (b_rst_done && !rst_b) begin
      b_hold++;
      if (b_hold == 2) begin
        #2;
        rst_b = 1'b1;
      end
    end
  endtask

  vec_t tbl [14];

  initial begin
    cfg_a = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, lat:1, pol:1'b0};
    cfg_b = '{ha:16, hfp:2, hsw:3, hbp:3, va:8, vfp:1, vsw:2, vbp:2, lat:3, pol:1'b1};

    tbl[0]  = '{t:1,    x:10'd0,   y:10'd0, act:1'b1, fs:1'b1, data:14'h3000};
    tbl[1]  = '{t:2,    x:10'd1,   y:10'd0, act:1'b1, fs:1'b0, data:14'h3000};
    tbl[2]  = '{t:3,    x:10'd2,   y:10'd0, act:1'b1, fs:1'b0, data:14'h3000};
    tbl[3]  = '{t:4,    x:10'd3,   y:10'd0, act:1'b1, fs:1'b0, data:14'h3001};
    tbl[4]  = '{t:640,  x:10'd639, y:10'd0, act:1'b1, fs:1'b0, data:14'h327D};
    tbl[5]  = '{t:641,  x:10'd640, y:10'd0, act:1'b0, fs:1'b0, data:14'h327E};
    tbl[6]  = '{t:643,  x:10'd642, y:10'd0, act:1'b0, fs:1'b0, data:14'h3000};
    tbl[7]  = '{t:659,  x:10'd658, y:10'd0, act:1'b0, fs:1'b0, data:14'h1000};
    tbl[8]  = '{t:754,  x:10'd753, y:10'd0, act:1'b0, fs:1'b0, data:14'h1000};
    tbl[9]  = '{t:755,  x:10'd754, y:10'd0, act:1'b0, fs:1'b0, data:14'h3000};
    tbl[10] = '{t:800,  x:10'd799, y:10'd0, act:1'b0, fs:1'b0, data:14'h3000};
    tbl[11] = '{t:801,  x:10'd0,   y:10'd1, act:1'b1, fs:1'b0, data:14'h3000};
    tbl[12] = '{t:804,  x:10'd3,   y:10'd1, act:1'b1, fs:1'b0, data:14'h3001};
    tbl[13] = '{t:2402, x:10'd1,   y:10'd3, act:1'b1, fs:1'b0, data:14'h3000};

    rst_a = 1'b0; rst_b = 1'b0;
    tp_a  = 1'b0; tp_b  = 1'b0;
    rgb_a = 12'($urandom); rgb_b = 12'($urandom);

    // Held in reset: idle outputs.
    repeat (3) step();
    chk("rst_data_a", 64'(data_a), 64'h3000);
    chk("rst_active_a", 64'(act_a), 64'd0);
    chk("rst_fs_a", 64'(fs_a), 64'd0);
    chk("rst_pix_a", 64'({px_a, py_a}), 64'd0);
    chk("rst_data_b", 64'(data_b), 64'h0000);

    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < 14; i++) begin
      while (ta < tbl[i].t) step();
      chk($sformatf("tbl%0d_pix", i), 64'({px_a, py_a, act_a, fs_a}),
          64'({tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].fs}));
      chk($sformatf("tbl%0d_data", i), 64'(data_a), 64'(tbl[i].data));
    end

`ifdef VGA_TEST_PATTERN_EN
    tp_a = 1'b1;
`endif
    while (ta < 2700) step();

`ifdef VGA_TEST_PATTERN_EN
    // Drop reset mid-line: outputs must be idle before the next edge.
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_async_rst_data", 64'(data_a), 64'h3000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
